jedro_1_ifu: RTL and testbench
==============================

Name: jedro_1_ifu

Overview:
- Instruction fetch unit for the jedro_1 core; sits directly upstream of the decoder.
- Generates sequential PCs and issues word reads to the synchronous instruction ROM (1-cycle read latency).
- Buffers returned words in a small prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Flushes and refetches on jump/branch redirects from the execute stage.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 4, prefetch FIFO entries (power of two, minimum 2).
- BOOT_ADDR, 32'h0000_0000, PC after reset (word aligned).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- imem_en_o  out  1  read request to the instruction ROM this cycle.
- imem_addr_o  out  ADDR_WIDTH  byte address of the read request.
- imem_rdata_i  in  DATA_WIDTH  ROM data; valid exactly one cycle after a request.
- jmp_instr_i  in  1  redirect request (taken branch or jump).
- jmp_addr_i  in  ADDR_WIDTH  redirect target.
- instr_o  out  DATA_WIDTH  instruction at the FIFO head.
- instr_addr_o  out  ADDR_WIDTH  PC of instr_o.
- instr_valid_o  out  1  instr_o/instr_addr_o are valid.
- instr_ready_i  in  1  decoder accepts the head entry this cycle.
- misaligned_o  out  1  one-cycle pulse: redirect target had [1:0] != 0.

Behaviour:
- Reset (rst_i=1 at a rising edge): pc_q=BOOT_ADDR; FIFO empty (count_q=0); inflight_q=0; kill_q=0. Outputs: instr_valid_o=0, imem_en_o=0, misaligned_o=0, instr_o=0, instr_addr_o=0.
- Reset mid-operation: everything above is cleared. ROM data returning in the following cycle is discarded.
- Issue rule:
  - imem_en_o=1 when not in reset and count_q + inflight_q < DEPTH, or in any redirect cycle.
  - imem_addr_o = pc_q, or {jmp_addr_i[ADDR_WIDTH-1:2],2'b00} in a redirect cycle.
  - On issue: pc_q <= imem_addr_o + 4, inflight_q <= 1, inflight_addr_q <= imem_addr_o. Otherwise inflight_q <= 0.
- Return: when inflight_q=1 and kill_q=0, {imem_rdata_i, inflight_addr_q} is pushed into the FIFO at the end of that cycle.
- Latency: instruction requested at cycle n appears on instr_o with instr_valid_o=1 at cycle n+2 at the earliest. There is no bypass.
- Handshake:
  - instr_valid_o = (count_q != 0).
  - Pop when instr_valid_o & instr_ready_i.
  - instr_o and instr_addr_o are held stable while valid and not ready.
- Throughput: 1 instruction per cycle sustained while instr_ready_i=1.
- Full: no issue when count_q + inflight_q == DEPTH, so a push can never hit a full FIFO.
- Simultaneous push and pop: count_q unchanged; head advances.
- Redirect (jmp_instr_i=1):
  - FIFO flushed (count_q <= 0, pointers reset).
  - The in-flight response, if any, is dropped (kill_q <= inflight_q).
  - A new request is issued the same cycle at the aligned target.
  - A pop in the same cycle is ignored; redirect has priority over pop and push.
  - First target instruction is valid at R+2.
- Back-to-back redirects: each one flushes; the last target wins.
- Misaligned target: address bits [1:0] are forced to 0 and misaligned_o pulses in the redirect cycle. Fetch proceeds from the aligned address.
- PC arithmetic is modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0 without error.

Decomposition:
- Package jedro_1_ifu_pkg holds:
  - the FIFO entry struct (instr, addr);
  - the IFU_DEPTH default;
  - the BOOT_ADDR default.
- Sub-module jedro_1_ifu_fifo: synchronous FIFO of that struct with push, pop, flush, count and head outputs.
- The top level contains the PC, issue/credit logic and kill tracking.

Test Plan:
- Reset release, ROM words 0..7 = 0x11..0x18, instr_ready_i=1 -> first instr_valid_o 2 cycles after the first imem_en_o. Sequence instr_addr_o 0,4,8,... carries 0x11,0x12,... at one per cycle with no gaps.
- Hold instr_ready_i=0 for 10 cycles -> count reaches DEPTH=4 and imem_en_o drops. instr_o stays 0x11 at addr 0. On release, 0x11..0x18 emerge in order with no loss or duplication.
- Redirect jmp_addr_i=0x40 while the FIFO holds 3 entries and 1 read is in flight -> no stale word is presented. Next valid output is addr 0x40, 2 cycles after the redirect, followed by 0x44.
- Redirect with jmp_addr_i=0x42 -> misaligned_o pulses 1 cycle and fetch resumes at 0x40. Two consecutive redirects to 0x80 then 0xC0 -> first valid output is 0xC0.
- Redirect in the same cycle as a pop with instr_ready_i=1 -> the popped entry is not re-presented and the next output is the target. BOOT_ADDR=32'hFFFF_FFF8 -> outputs addr FFFF_FFF8, FFFF_FFFC, 0, 4.
- Assert rst_i for 1 cycle mid-stream with 2 entries buffered -> instr_valid_o=0 the next cycle. Refetch starts at BOOT_ADDR and the pre-reset in-flight word is never output.

Source files
------------

// File: rtl/jedro_1_ifu_pkg.sv
// Shared types and defaults for the jedro_1 instruction fetch unit.
package jedro_1_ifu_pkg;

   localparam int unsigned IFU_ADDR_WIDTH = 32;
   localparam int unsigned IFU_DATA_WIDTH = 32;
   localparam int unsigned IFU_DEPTH      = 4;
   localparam logic [IFU_ADDR_WIDTH-1:0] IFU_BOOT_ADDR = 32'h0000_0000;

   // One prefetch FIFO entry: fetched instruction word and the PC it came from.
   typedef struct packed {
      logic [IFU_DATA_WIDTH-1:0] instr;
      logic [IFU_ADDR_WIDTH-1:0] addr;
   } ifu_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Prefetch FIFO for the jedro_1 IFU: synchronous, power-of-two depth, flushable.
// Push/pop are expected to be qualified by the caller; flush has priority.
module jedro_1_ifu_fifo
   import jedro_1_ifu_pkg::*;
#(
   parameter int unsigned DEPTH = IFU_DEPTH
)(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  ifu_entry_t              push_data_i,
   input  logic                    pop_i,
   output ifu_entry_t              head_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   ifu_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   // Entry storage; data path only, not reset.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         r_mem[r_wptr] <= push_data_i;
      end
   end

   // Read/write pointers and occupancy; reset and flush both empty the queue.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (push_i) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (pop_i) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_o  = r_mem[r_rptr];
   assign count_o = r_count;

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: sequential PC generation, credit-limited
// ROM reads, prefetch buffering and flush/refetch on execute-stage redirects.
module jedro_1_ifu
   import jedro_1_ifu_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = IFU_ADDR_WIDTH,
   parameter int unsigned           DATA_WIDTH = IFU_DATA_WIDTH,
   parameter int unsigned           DEPTH      = IFU_DEPTH,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(IFU_BOOT_ADDR)
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  imem_en_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   input  logic                  jmp_instr_i,
   input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic                  misaligned_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_inflight;
   logic [ADDR_WIDTH-1:0] r_inflight_addr;

   logic                  w_redirect;
   logic [ADDR_WIDTH-1:0] w_target;
   logic                  w_credit;
   logic                  w_issue;
   logic [ADDR_WIDTH-1:0] w_issue_addr;
   logic                  w_kill;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_valid;
   logic [CNT_W-1:0]      w_count;
   ifu_entry_t            w_push_entry;
   ifu_entry_t            w_head;

   assign w_redirect = jmp_instr_i & ~rst_i;
   assign w_target   = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};

   // Buffered plus in-flight words may never exceed the FIFO depth, so a
   // returning word always has a free slot.
   assign w_credit = (w_count + CNT_W'(r_inflight)) < CNT_W'(DEPTH);

   // Issue decision: a redirect always issues at its aligned target.
   always_comb begin
      w_issue      = 1'b0;
      w_issue_addr = r_pc;
      if (!rst_i) begin
         if (jmp_instr_i) begin
            w_issue      = 1'b1;
            w_issue_addr = w_target;
         end else if (w_credit) begin
            w_issue = 1'b1;
         end
      end
   end

   // With a one-cycle ROM, the response that is in flight during a redirect
   // returns in that same cycle, so it is dropped right there; the request
   // issued by the redirect itself is always live.
   assign w_kill  = r_inflight & w_redirect;
   assign w_push  = r_inflight & ~w_kill & ~w_redirect & ~rst_i;
   assign w_valid = (w_count != '0);
   assign w_pop   = w_valid & instr_ready_i & ~w_redirect & ~rst_i;

   assign w_push_entry.instr = IFU_DATA_WIDTH'(imem_rdata_i);
   assign w_push_entry.addr  = IFU_ADDR_WIDTH'(r_inflight_addr);

   // PC and in-flight request tracking; PC wraps modulo 2^ADDR_WIDTH.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc            <= BOOT_ADDR;
         r_inflight      <= 1'b0;
         r_inflight_addr <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc            <= w_issue_addr + ADDR_WIDTH'(4);
            r_inflight_addr <= w_issue_addr;
         end
      end
   end

   jedro_1_ifu_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (w_redirect),
      .push_i      (w_push),
      .push_data_i (w_push_entry),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .count_o     (w_count)
   );

   assign imem_en_o     = w_issue;
   assign imem_addr_o   = w_issue_addr;
   assign misaligned_o  = w_redirect & (jmp_addr_i[1:0] != 2'b00);
   assign instr_valid_o = w_valid;
   assign instr_o       = w_valid ? DATA_WIDTH'(w_head.instr) : '0;
   assign instr_addr_o  = w_valid ? ADDR_WIDTH'(w_head.addr)  : '0;

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu: directed scenarios plus a randomized
// run compared against an in-order expected-PC stream model.
module tb_jedro_1_ifu;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        jmp;
   logic [31:0] jmp_addr;
   logic [31:0] instr;
   logic [31:0] iaddr;
   logic        valid;
   logic        ready;
   logic        mis;

   logic        rst2;
   logic        en2;
   logic [31:0] addr2;
   logic [31:0] rdata2;
   logic        jmp2;
   logic [31:0] jmp_addr2;
   logic [31:0] instr2;
   logic [31:0] iaddr2;
   logic        valid2;
   logic        ready2;
   logic        mis2;

   int n_vec;
   int n_err;

   jedro_1_ifu u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_en_o     (en),
      .imem_addr_o   (addr),
      .imem_rdata_i  (rdata),
      .jmp_instr_i   (jmp),
      .jmp_addr_i    (jmp_addr),
      .instr_o       (instr),
      .instr_addr_o  (iaddr),
      .instr_valid_o (valid),
      .instr_ready_i (ready),
      .misaligned_o  (mis)
   );

   jedro_1_ifu #(
      .BOOT_ADDR (32'hFFFF_FFF8)
   ) u_wrap (
      .clk_i         (clk),
      .rst_i         (rst2),
      .imem_en_o     (en2),
      .imem_addr_o   (addr2),
      .imem_rdata_i  (rdata2),
      .jmp_instr_i   (jmp2),
      .jmp_addr_i    (jmp_addr2),
      .instr_o       (instr2),
      .instr_addr_o  (iaddr2),
      .instr_valid_o (valid2),
      .instr_ready_i (ready2),
      .misaligned_o  (mis2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: words 0..7 are 0x11..0x18, elsewhere an address-unique pattern.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a < 32'd32) return 32'h11 + 32'(a[4:2]);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   // Synchronous ROMs with one-cycle latency; garbage when not read.
   always @(posedge clk) begin
      rdata  <= en  ? rom_word(addr)  : 32'hDEAD_BEEF;
      rdata2 <= en2 ? rom_word(addr2) : 32'hDEAD_BEEF;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      jmp = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; jmp = 1'b0; jmp_addr = 32'h0; ready = 1'b1;
      tick(); tick();
      jmp = 1'b1; jmp_addr = 32'h43;
      #1;
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", valid); end
      n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %0b want 0", en); end
      n_vec++; if (mis !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %0b want 0", mis); end
      n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
      n_vec++; if (iaddr !== 32'h0) begin n_err++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
      jmp = 1'b0;
      tick();
   endtask

   // Runs right after test_reset: reset still asserted on entry.
   task automatic test_stream();
      rst = 1'b0; ready = 1'b1;
      #1;
      n_vec++; if (en !== 1'b1 || addr !== 32'h0) begin n_err++; $display("FAIL stream_first_issue: got en=%0b addr=%h want en=1 addr=0", en, addr); end
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL stream_c0_valid: got %0b want 0", valid); end
      tick();
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid: got %0b want 0", valid); end
      tick();
      for (int k = 0; k < 16; k++) begin
         n_vec++;
         if (valid !== 1'b1 || iaddr !== 32'(4 * k) || instr !== rom_word(32'(4 * k))) begin
            n_err++;
            $display("FAIL stream_word%0d: got v=%0b a=%h d=%h want v=1 a=%h d=%h",
                     k, valid, iaddr, instr, 32'(4 * k), rom_word(32'(4 * k)));
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int got;
      apply_reset();
      ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (k >= 2) begin
            n_vec++;
            if (valid !== 1'b1 || iaddr !== 32'h0 || instr !== 32'h11) begin
               n_err++;
               $display("FAIL hold_head%0d: got v=%0b a=%h d=%h want v=1 a=0 d=11", k, valid, iaddr, instr);
            end
         end
         tick();
      end
      ready = 1'b1;
      #1;
      n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL hold_full_en: got %0b want 0", en); end
      got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (c != 0) #1;
         if (valid === 1'b1) begin
            n_vec++;
            if (iaddr !== 32'(4 * got) || instr !== 32'(32'h11 + got)) begin
               n_err++;
               $display("FAIL drain%0d: got a=%h d=%h want a=%h d=%h", got, iaddr, instr, 32'(4 * got), 32'(32'h11 + got));
            end
            got++;
         end
         tick();
      end
      n_vec++; if (got != 8) begin n_err++; $display("FAIL drain_count: got %0d want 8", got); end
   endtask

   task automatic test_redirect();
      apply_reset();
      ready = 1'b0;
      tick(); tick(); tick(); tick();
      jmp = 1'b1; jmp_addr = 32'h40;
      #1;
      n_vec++; if (en !== 1'b1 || addr !== 32'h40) begin n_err++; $display("FAIL redir_issue: got en=%0b addr=%h want 1/40", en, addr); end
      n_vec++; if (mis !== 1'b0) begin n_err++; $display("FAIL redir_mis: got %0b want 0", mis); end
      tick();
      jmp = 1'b0;
      #1;
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL redir_r1_valid: got %0b want 0", valid); end
      tick();
      ready = 1'b1;
      #1;
      n_vec++; if (valid !== 1'b1 || iaddr !== 32'h40 || instr !== rom_word(32'h40)) begin n_err++; $display("FAIL redir_r2: got v=%0b a=%h d=%h want 1/40/%h", valid, iaddr, instr, rom_word(32'h40)); end
      tick();
      n_vec++; if (valid !== 1'b1 || iaddr !== 32'h44) begin n_err++; $display("FAIL redir_r3: got v=%0b a=%h want 1/44", valid, iaddr); end
      tick();
   endtask

   task automatic test_misaligned();
      ready = 1'b1;
      jmp = 1'b1; jmp_addr = 32'h42;
      #1;
      n_vec++; if (mis !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %0b want 1", mis); end
      n_vec++; if (en !== 1'b1 || addr !== 32'h40) begin n_err++; $display("FAIL mis_issue: got en=%0b addr=%h want 1/40", en, addr); end
      tick();
      jmp = 1'b0;
      #1;
      n_vec++; if (mis !== 1'b0) begin n_err++; $display("FAIL mis_oneshot: got %0b want 0", mis); end
      tick();
      n_vec++; if (valid !== 1'b1 || iaddr !== 32'h40) begin n_err++; $display("FAIL mis_resume: got v=%0b a=%h want 1/40", valid, iaddr); end
      tick();
      jmp = 1'b1; jmp_addr = 32'h80;
      tick();
      jmp_addr = 32'hC0;
      #1;
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_r1_valid: got %0b want 0", valid); end
      tick();
      jmp = 1'b0;
      #1;
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_r2_valid: got %0b want 0", valid); end
      tick();
      n_vec++; if (valid !== 1'b1 || iaddr !== 32'hC0 || instr !== rom_word(32'hC0)) begin n_err++; $display("FAIL b2b_target: got v=%0b a=%h d=%h want 1/C0/%h", valid, iaddr, instr, rom_word(32'hC0)); end
      tick();
   endtask

   task automatic test_pop_redirect();
      ready = 1'b1;
      tick();
      jmp = 1'b1; jmp_addr = 32'h100;
      #1;
      n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL popredir_head: got %0b want 1", valid); end
      tick();
      jmp = 1'b0;
      #1;
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL popredir_flush: got %0b want 0", valid); end
      tick();
      n_vec++; if (valid !== 1'b1 || iaddr !== 32'h100 || instr !== rom_word(32'h100)) begin n_err++; $display("FAIL popredir_target: got v=%0b a=%h d=%h want 1/100/%h", valid, iaddr, instr, rom_word(32'h100)); end
      tick();
   endtask

   task automatic test_midreset();
      apply_reset();
      ready = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      n_vec++; if (en !== 1'b0) begin n_err++; $display("FAIL midrst_en: got %0b want 0", en); end
      tick();
      rst = 1'b0; ready = 1'b1;
      #1;
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b want 0", valid); end
      n_vec++; if (en !== 1'b1 || addr !== 32'h0) begin n_err++; $display("FAIL midrst_refetch: got en=%0b addr=%h want 1/0", en, addr); end
      tick();
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL midrst_c1_valid: got %0b want 0", valid); end
      tick();
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (valid !== 1'b1 || iaddr !== 32'(4 * k) || instr !== 32'(32'h11 + k)) begin
            n_err++;
            $display("FAIL midrst_word%0d: got v=%0b a=%h d=%h want 1/%h/%h", k, valid, iaddr, instr, 32'(4 * k), 32'(32'h11 + k));
         end
         tick();
      end
   endtask

   // Random ready/redirect traffic against an in-order expected-PC model.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] tgt;
      logic        p_valid, p_ready, p_jmp;
      logic [31:0] p_instr, p_iaddr;
      int          since_jmp;
      apply_reset();
      exp_pc = 32'h0; p_valid = 1'b0; p_ready = 1'b0; p_jmp = 1'b0;
      p_instr = 32'h0; p_iaddr = 32'h0; since_jmp = 100; tgt = 32'h0;
      for (int c = 0; c < 400; c++) begin
         ready = ($urandom_range(0, 9) < 7);
         jmp   = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = 32'($urandom_range(0, 255));
            1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: tgt = 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFC;
         endcase
         jmp_addr = jmp ? tgt : $urandom;
         #1;
         n_vec++;
         if (mis !== (jmp && (jmp_addr[1:0] != 2'b00))) begin
            n_err++; $display("FAIL rnd_mis c%0d: got %0b want %0b", c, mis, jmp && (jmp_addr[1:0] != 2'b00));
         end
         if (jmp) begin
            n_vec++;
            if (en !== 1'b1 || addr !== (tgt & 32'hFFFF_FFFC)) begin
               n_err++; $display("FAIL rnd_redir_issue c%0d: got en=%0b addr=%h want 1/%h", c, en, addr, tgt & 32'hFFFF_FFFC);
            end
         end
         if (p_jmp) begin
            n_vec++;
            if (valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush c%0d: got %0b want 0", c, valid); end
         end else if (p_valid && !p_ready) begin
            n_vec++;
            if (valid !== 1'b1 || instr !== p_instr || iaddr !== p_iaddr) begin
               n_err++; $display("FAIL rnd_hold c%0d: got v=%0b a=%h d=%h want 1/%h/%h", c, valid, iaddr, instr, p_iaddr, p_instr);
            end
         end
         if (since_jmp == 2) begin
            n_vec++;
            if (valid !== 1'b1) begin n_err++; $display("FAIL rnd_latency c%0d: got %0b want 1", c, valid); end
         end
         if (valid === 1'b1) begin
            n_vec++;
            if (iaddr !== exp_pc || instr !== rom_word(exp_pc)) begin
               n_err++; $display("FAIL rnd_order c%0d: got a=%h d=%h want a=%h d=%h", c, iaddr, instr, exp_pc, rom_word(exp_pc));
            end
            if (ready && !jmp) exp_pc = exp_pc + 32'd4;
         end
         if (jmp) begin
            exp_pc    = tgt & 32'hFFFF_FFFC;
            since_jmp = 0;
         end
         p_valid = valid; p_ready = ready; p_jmp = jmp; p_instr = instr; p_iaddr = iaddr;
         tick();
         if (since_jmp < 100) since_jmp++;
      end
      jmp = 1'b0;
   endtask

   task automatic test_wrap();
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      #1;
      n_vec++; if (en2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_boot: got en=%0b addr=%h want 1/FFFFFFF8", en2, addr2); end
      tick(); tick();
      for (int k = 0; k < 4; k++) begin
         logic [31:0] ea;
         ea = 32'hFFFF_FFF8 + 32'(4 * k);
         n_vec++;
         if (valid2 !== 1'b1 || iaddr2 !== ea || instr2 !== rom_word(ea)) begin
            n_err++; $display("FAIL wrap_word%0d: got v=%0b a=%h d=%h want 1/%h/%h", k, valid2, iaddr2, instr2, ea, rom_word(ea));
         end
         tick();
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; jmp = 1'b0; jmp_addr = 32'h0; ready = 1'b0;
      rst2 = 1'b1; jmp2 = 1'b0; jmp_addr2 = 32'h0; ready2 = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misaligned();
      test_pop_redirect();
      test_midreset();
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
